// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: cycle-type codes, arbiter states and index sizing.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [0:0] {
    StIdle,
    StOwned
  } arb_state_e;

  // Index width for n requesters; never below 1 so a 1-entry index stays legal.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned MaxMasters = 8;
  localparam int unsigned MaxIdxW    = idx_w(MaxMasters);

endpackage

// File: rtl/wb_bus_arbiter_if.sv
// Bundle of requester-side and slave-side Wishbone signals around the arbiter.
interface wb_bus_arbiter_if #(
    parameter int unsigned NUM_MASTERS   = 3,
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned DATA_BYTES    = 1
) ();

    logic [NUM_MASTERS-1:0]               m_cyc_i;
    logic [NUM_MASTERS-1:0]               m_stb_i;
    logic [NUM_MASTERS-1:0]               m_we_i;
    logic [NUM_MASTERS*DATA_BYTES-1:0]    m_sel_i;
    logic [NUM_MASTERS*ADDRESS_WIDTH-1:0] m_adr_i;
    logic [NUM_MASTERS*DATA_WIDTH-1:0]    m_dat_i;
    logic [NUM_MASTERS*3-1:0]             m_cti_i;
    logic [NUM_MASTERS-1:0]               m_ack_o;
    logic [NUM_MASTERS-1:0]               m_err_o;
    logic [NUM_MASTERS-1:0]               m_gnt_o;
    logic [DATA_WIDTH-1:0]                m_dat_o;

    logic                     s_cyc_o;
    logic                     s_stb_o;
    logic                     s_we_o;
    logic [DATA_BYTES-1:0]    s_sel_o;
    logic [ADDRESS_WIDTH-1:0] s_adr_o;
    logic [DATA_WIDTH-1:0]    s_dat_o;
    logic [2:0]               s_cti_o;
    logic                     s_ack_i;
    logic                     s_err_i;
    logic [DATA_WIDTH-1:0]    s_dat_i;

    // Arbiter view.
    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, m_cti_i,
        output m_ack_o, m_err_o, m_gnt_o, m_dat_o,
        output s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, s_cti_o,
        input  s_ack_i, s_err_i, s_dat_i
    );

    // Environment view: requesters plus the downstream slave.
    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_sel_i, m_adr_i, m_dat_i, m_cti_i,
        input  m_ack_o, m_err_o, m_gnt_o, m_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o, s_cti_o,
        output s_ack_i, s_err_i, s_dat_i
    );

endinterface

// File: rtl/wb_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request after last_i, wrapping.
module rr_pick
    import wb_pkg::*;
#(
    parameter int unsigned N    = 3,
    parameter int unsigned IdxW = idx_w(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] last_i,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);

    int unsigned cand;

    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = 0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = (32'(last_i) + i) % N;
            if (!valid_o && req_i[cand[IdxW-1:0]]) begin
                valid_o = 1'b1;
                idx_o   = cand[IdxW-1:0];
            end
        end
    end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Round-robin Wishbone arbiter; grant held until the owner drops cyc.
// Optional stall timeout abort enabled by defining WB_ARB_TIMEOUT_EN.
module wb_bus_arbiter
    import wb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS   = 3,
    parameter int unsigned ADDRESS_WIDTH = 16,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned DATA_BYTES    = 1,
    parameter int unsigned MAX_WAIT      = 255
) (
    input logic                clk_48mhz,
    input logic                rst,
    wb_bus_arbiter_if.slave    bus
);

    localparam int unsigned IdxW = idx_w(NUM_MASTERS);

    if (NUM_MASTERS < 2 || NUM_MASTERS > MaxMasters || MAX_WAIT < 1) begin : g_param_check
        $fatal(1, "wb_bus_arbiter: unsupported NUM_MASTERS or MAX_WAIT");
    end

    arb_state_e      state_q;
    logic [IdxW-1:0] owner_q;
    logic [IdxW-1:0] last_q;
    logic [IdxW-1:0] pick_idx;
    logic            pick_valid;
    logic            owned;
    logic            timeout;

    rr_pick #(
        .N    (NUM_MASTERS),
        .IdxW (IdxW)
    ) u_rr_pick (
        .req_i   (bus.m_cyc_i),
        .last_i  (last_q),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    assign owned = (state_q == StOwned);

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(MAX_WAIT + 1) > 8) ? $clog2(MAX_WAIT + 1) : 8;

    logic [CntW-1:0] wait_q;
    logic            stb_req;

    assign stb_req = owned && bus.m_stb_i[owner_q];
    // Fires on the MAX_WAIT-th consecutive unanswered strobe cycle.
    assign timeout = stb_req && !bus.s_ack_i && !bus.s_err_i &&
                     (wait_q == CntW'(MAX_WAIT - 1));

    always_ff @(posedge clk_48mhz or posedge rst) begin
        if (rst) begin
            wait_q <= '0;
        end else if (!stb_req || bus.s_ack_i || bus.s_err_i || timeout) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_q + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_48mhz or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            owner_q <= '0;
            last_q  <= IdxW'(NUM_MASTERS - 1);
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        state_q <= StOwned;
                        owner_q <= pick_idx;
                        last_q  <= pick_idx;
                    end
                end
                StOwned: begin
                    if (!bus.m_cyc_i[owner_q] || timeout) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        bus.m_gnt_o = '0;
        bus.m_ack_o = '0;
        bus.m_err_o = '0;
        bus.m_dat_o = bus.s_dat_i;
        bus.s_cyc_o = 1'b0;
        bus.s_stb_o = 1'b0;
        bus.s_we_o  = 1'b0;
        bus.s_sel_o = '0;
        bus.s_adr_o = '0;
        bus.s_dat_o = '0;
        bus.s_cti_o = CTI_CLASSIC;
        if (owned) begin
            bus.m_gnt_o[owner_q] = 1'b1;
            bus.m_ack_o[owner_q] = bus.s_ack_i;
            bus.m_err_o[owner_q] = bus.s_err_i || timeout;
            bus.s_cyc_o = bus.m_cyc_i[owner_q] && !timeout;
            bus.s_stb_o = bus.m_stb_i[owner_q] && !timeout;
            bus.s_we_o  = bus.m_we_i[owner_q];
            bus.s_sel_o = bus.m_sel_i[owner_q*DATA_BYTES +: DATA_BYTES];
            bus.s_adr_o = bus.m_adr_i[owner_q*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            bus.s_dat_o = bus.m_dat_i[owner_q*DATA_WIDTH +: DATA_WIDTH];
            bus.s_cti_o = bus.m_cti_i[owner_q*3 +: 3];
        end
    end

endmodule

// File: doc/wb_bus_arbiter.md
Name: wb_bus_arbiter

Overview:
Round-robin Wishbone (classic + CTI) arbiter that shares one slave-side bus between NUM_MASTERS requesters, e.g. the USB protocol bridge, the synth sequencer and a test master. It replaces the ad-hoc fixed-priority mux and cross-coupled cycle-blocking wires in the top level. Downstream address decode and ack/data collection stay outside; this block owns grant, muxing, and ack/err routing. The block runs on clk_48mhz.

Parameters:
NUM_MASTERS, 3, number of requesters (2..8)
ADDRESS_WIDTH, 16, Wishbone address width
DATA_WIDTH, 8, Wishbone data width
DATA_BYTES, 1, select lanes per master
MAX_WAIT, 255, stall cycles before timeout abort (timeout feature only)

Ports:
clk_48mhz  in  1  clock
rst  in  1  reset: asynchronous, active-high
m_cyc_i  in  NUM_MASTERS  per-master cycle request
m_stb_i  in  NUM_MASTERS  per-master strobe
m_we_i  in  NUM_MASTERS  per-master write enable
m_sel_i  in  NUM_MASTERS*DATA_BYTES  packed selects, master i at [i*DATA_BYTES +: DATA_BYTES]
m_adr_i  in  NUM_MASTERS*ADDRESS_WIDTH  packed addresses
m_dat_i  in  NUM_MASTERS*DATA_WIDTH  packed write data
m_cti_i  in  NUM_MASTERS*3  packed cycle type
m_ack_o  out  NUM_MASTERS  ack, owner only
m_err_o  out  NUM_MASTERS  error, owner only
m_gnt_o  out  NUM_MASTERS  one-hot grant
m_dat_o  out  DATA_WIDTH  read data, broadcast
s_cyc_o, s_stb_o, s_we_o  out  1 each  slave-side controls
s_sel_o  out  DATA_BYTES  slave select
s_adr_o  out  ADDRESS_WIDTH  slave address
s_dat_o  out  DATA_WIDTH  slave write data
s_cti_o  out  3  slave cycle type
s_ack_i  in  1  slave ack (OR of all slaves)
s_err_i  in  1  slave error
s_dat_i  in  DATA_WIDTH  slave read data (already muxed)

Behaviour:
- FSM states: IDLE, OWNED. Registers: state_q, owner_q (index), last_q (index of last grantee).
- Reset: state_q=IDLE, owner_q=0, last_q=NUM_MASTERS-1, so master 0 wins first. All outputs are 0 while in reset and in IDLE.
- IDLE: if any m_cyc_i is high, the next cycle enters OWNED. owner_q is the first requester searching from last_q+1 upward, wrapping modulo NUM_MASTERS. last_q is set to that index. There is no grant when no request is present.
- Grant latency: 1 cycle from a request in IDLE to m_gnt_o[owner] and s_cyc_o.
- OWNED: m_gnt_o is one-hot on owner_q. s_cyc_o=m_cyc_i[owner], s_stb_o=m_stb_i[owner], and the remaining s_* fields are the owner's slices (combinational mux, no added latency).
- OWNED: m_ack_o[owner]=s_ack_i and m_err_o[owner]=s_err_i; all other bits are 0. m_dat_o=s_dat_i at all times.
- Release: when m_cyc_i[owner] is low in OWNED, the next state is IDLE. This gives one dead cycle between owners, with all s_* at 0.
- The grant is held across multi-beat bursts (cti 001/010) for as long as the owner holds cyc. There is no preemption.
- Requests from non-owners are ignored until IDLE. A non-owner's ack/err is always 0.
- Simultaneous release and new requests: release takes priority. Arbitration happens in the following IDLE cycle.
- Reset asserted mid-cycle: all outputs drop asynchronously. The aborted master sees no ack and must retry.

Optional Feature:
Macro WB_ARB_TIMEOUT_EN.
- With the macro defined: an 8-bit-or-wider counter clears on any s_ack_i/s_err_i or when s_stb_o is low, and increments while s_stb_o is high. When it reaches MAX_WAIT:
  - m_err_o[owner] pulses for one cycle;
  - s_cyc_o and s_stb_o are forced to 0 in that same cycle;
  - the state returns to IDLE;
  - the counter clears.
  The master is expected to drop cyc on err.
- Without the macro: no counter exists, m_err_o carries only s_err_i, and a hung slave holds the bus indefinitely.

Decomposition:
- Package wb_pkg holds:
  - CTI constants (CTI_CLASSIC=3'b000, CTI_CONST=3'b001, CTI_INCR=3'b010, CTI_EOB=3'b111);
  - the arbiter state enum;
  - a clog2-based index width constant.
- One sub-module, rr_pick. It is combinational: request vector + last index -> next index + valid. It is reused by future interrupt and DMA schedulers.

Test Plan:
- Reset release, master 1 alone raises cyc/stb (adr 16'h0100, we=1, dat 8'hA5) -> gnt=3'b010 after 1 cycle, s_adr_o=16'h0100, s_dat_o=8'hA5, ack routed only to m_ack_o[1].
- Masters 0 and 2 request in the same IDLE cycle after reset -> master 0 granted. After it releases, one dead cycle, then master 2 is granted.
- All three masters hold requests continuously for 6 transactions -> grant order 0,1,2,0,1,2.
- Master 0 performs a 4-beat INCR burst (cti 010,010,010,111) while master 1 requests -> master 1 is not granted until master 0 drops cyc, and all 4 acks go to master 0.
- Slave never acks with MAX_WAIT=16 and WB_ARB_TIMEOUT_EN defined -> m_err_o[owner] pulses exactly at stall cycle 16 and s_cyc_o drops the same cycle. With the macro undefined, the bus stays owned.
- rst asserted during an active read -> all s_* and m_gnt_o go to 0 immediately. After release, last_q=NUM_MASTERS-1, so master 0 wins next.
